// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the two client request/response ports (a_*, b_*) and
//             the memory read/write port driven by the arbiter.
//  Modports : slave  - arbiter side. It receives client requests and memory
//                      read data, and drives grants, responses and all
//                      memory control, address and data pins.
//             master - client/memory side. It drives requests and
//                      mem_rd_data, and receives everything else.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int DW = 8,
   parameter int AW = 7
);
   // Client A
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;
   logic          a_err;
   // Client B
   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_gnt;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;
   logic          b_err;
   // Memory
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      input  b_req, b_we, b_addr, b_wdata,
      input  mem_rd_data,
      output a_gnt, a_rvalid, a_rdata, a_err,
      output b_gnt, b_rvalid, b_rdata, b_err,
      output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      output b_req, b_we, b_addr, b_wdata,
      output mem_rd_data,
      input  a_gnt, a_rvalid, a_rdata, a_err,
      input  b_gnt, b_rvalid, b_rdata, b_err,
      input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter in front of a single-clock memory
//             that has separate read and write ports. A read and a write
//             from different clients can be granted in the same cycle. Read
//             data is routed back to the client that issued the read, with
//             a fixed latency of one cycle.
//  Ports    : clk    - clock; all state updates on the rising edge
//             rst_n  - asynchronous reset, active low
//             bus    - mem_arbiter_if.slave:
//                        a_/b_ req, we, addr, wdata  (in)
//                        a_/b_ gnt (combinational), rvalid, rdata, err (out)
//                        mem_rd_en/addr, mem_wr_en/addr/data (out)
//                        mem_rd_data (in, valid the cycle after mem_rd_en)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int DEPTH = 100,
   parameter int DW    = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  wire logic    clk,
   input  wire logic    rst_n,
   mem_arbiter_if.slave bus
);

   // The address is extended by one bit so that DEPTH itself is always
   // representable in the range comparison.
   localparam logic [AW:0] c_depth = DEPTH[AW:0];

   localparam int c_port_a = 0;
   localparam int c_port_b = 1;

   // ---------------------------------------------------------------------
   // Per-port views of the interface (index 0 = A, 1 = B)
   // ---------------------------------------------------------------------
   logic [1:0]    w_req;
   logic [1:0]    w_we;
   logic [AW-1:0] w_addr  [2];
   logic [DW-1:0] w_wdata [2];
   logic [1:0]    w_oor;        // request address is outside 0..DEPTH-1
   logic [1:0]    w_gnt;
   logic [1:0]    w_rd_gnt;     // granted read (any address)
   logic [1:0]    w_rd_mem;     // granted read that touches memory
   logic [1:0]    w_wr_mem;     // granted write that touches memory
   logic [1:0]    w_rvalid;
   logic [1:0]    w_err;
   logic [DW-1:0] w_rdata [2];

   logic          w_conflict;
   logic          r_prio_b;     // 1 = port B wins the next conflict

   assign w_req[c_port_a]   = bus.a_req;
   assign w_req[c_port_b]   = bus.b_req;
   assign w_we[c_port_a]    = bus.a_we;
   assign w_we[c_port_b]    = bus.b_we;
   assign w_addr[c_port_a]  = bus.a_addr;
   assign w_addr[c_port_b]  = bus.b_addr;
   assign w_wdata[c_port_a] = bus.a_wdata;
   assign w_wdata[c_port_b] = bus.b_wdata;

   // ---------------------------------------------------------------------
   // Grant decision
   // Two reads or two writes cannot share the single read or write port.
   // A read and a write to the same address are serialized instead of
   // forwarded, which keeps the read data path a plain memory read.
   // ---------------------------------------------------------------------
   assign w_conflict = (bus.a_we == bus.b_we) || (bus.a_addr == bus.b_addr);

   always_comb begin
      w_gnt = 2'b00;
      // Grants are forced low during reset even though they are combinational.
      if (rst_n) begin
         if (w_req[c_port_a] && w_req[c_port_b]) begin
            if (w_conflict) begin
               w_gnt[c_port_a] = ~r_prio_b;
               w_gnt[c_port_b] = r_prio_b;
            end else begin
               w_gnt = 2'b11;
            end
         end else begin
            w_gnt = w_req;
         end
      end
   end

   // Priority passes to the loser only on a conflict cycle. Single-requester
   // and dual-grant cycles leave it unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio_b <= 1'b0;
      end else if (w_req[c_port_a] && w_req[c_port_b] && w_conflict) begin
         r_prio_b <= ~r_prio_b;
      end
   end

   // ---------------------------------------------------------------------
   // Per-port access qualification and response registers
   // ---------------------------------------------------------------------
   generate
      for (genvar p = 0; p < 2; p++) begin : g_port
         logic r_rvalid;
         logic r_from_mem;   // response data comes from the memory read port
         logic r_err;

         assign w_oor[p]    = ({1'b0, w_addr[p]} >= c_depth);
         assign w_rd_gnt[p] = w_gnt[p] & ~w_we[p];
         assign w_rd_mem[p] = w_rd_gnt[p] & ~w_oor[p];
         assign w_wr_mem[p] = w_gnt[p] & w_we[p] & ~w_oor[p];

         // An out-of-range read still completes (rvalid, data 0) so that
         // the client never waits for a response that does not arrive.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rvalid   <= 1'b0;
               r_from_mem <= 1'b0;
               r_err      <= 1'b0;
            end else begin
               r_rvalid   <= w_rd_gnt[p];
               r_from_mem <= w_rd_mem[p];
               r_err      <= w_gnt[p] & w_oor[p];
            end
         end

         assign w_rvalid[p] = r_rvalid;
         assign w_err[p]    = r_err;
         assign w_rdata[p]  = r_from_mem ? bus.mem_rd_data : '0;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Memory port steering
   // The grant rule never admits two reads or two writes in one cycle, so
   // a simple priority mux selects the single active port. Address and
   // data are zero whenever the corresponding enable is low.
   // ---------------------------------------------------------------------
   always_comb begin
      bus.mem_rd_en   = 1'b0;
      bus.mem_rd_addr = '0;
      if (w_rd_mem[c_port_a]) begin
         bus.mem_rd_en   = 1'b1;
         bus.mem_rd_addr = w_addr[c_port_a];
      end else if (w_rd_mem[c_port_b]) begin
         bus.mem_rd_en   = 1'b1;
         bus.mem_rd_addr = w_addr[c_port_b];
      end
   end

   always_comb begin
      bus.mem_wr_en   = 1'b0;
      bus.mem_wr_addr = '0;
      bus.mem_wr_data = '0;
      if (w_wr_mem[c_port_a]) begin
         bus.mem_wr_en   = 1'b1;
         bus.mem_wr_addr = w_addr[c_port_a];
         bus.mem_wr_data = w_wdata[c_port_a];
      end else if (w_wr_mem[c_port_b]) begin
         bus.mem_wr_en   = 1'b1;
         bus.mem_wr_addr = w_addr[c_port_b];
         bus.mem_wr_data = w_wdata[c_port_b];
      end
   end

   // ---------------------------------------------------------------------
   // Client outputs
   // ---------------------------------------------------------------------
   assign bus.a_gnt    = w_gnt[c_port_a];
   assign bus.a_rvalid = w_rvalid[c_port_a];
   assign bus.a_rdata  = w_rdata[c_port_a];
   assign bus.a_err    = w_err[c_port_a];

   assign bus.b_gnt    = w_gnt[c_port_b];
   assign bus.b_rvalid = w_rvalid[c_port_b];
   assign bus.b_rdata  = w_rdata[c_port_b];
   assign bus.b_err    = w_err[c_port_b];

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed self-checking bench for mem_arbiter. Inputs change
//             just after the falling edge. Checks are made 1 ns later, when
//             both the combinational grant/memory outputs of the current
//             cycle and the registered responses of the previous cycle
//             are stable.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int DEPTH = 100;
   localparam int DW    = 8;
   localparam int AW    = 7;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [DW-1:0] mem_model [128];

   mem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

   mem_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple synchronous memory: writes on the edge, read data one cycle later.
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem_model[bus.mem_wr_addr] <= bus.mem_wr_data;
      if (bus.mem_rd_en) bus.mem_rd_data <= mem_model[bus.mem_rd_addr];
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_a(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 128; i++) mem_model[i] = '0;

      // ---------------- Reset: outputs low even with requests present ------
      rst_n = 1'b0;
      set_a(1'b1, 1'b0, 7'd3, 8'h00);
      set_b(1'b1, 1'b1, 7'd4, 8'h11);
      #3;
      chk("rst_a_gnt",    bus.a_gnt,       0);
      chk("rst_b_gnt",    bus.b_gnt,       0);
      chk("rst_a_rvalid", bus.a_rvalid,    0);
      chk("rst_b_rvalid", bus.b_rvalid,    0);
      chk("rst_a_rdata",  bus.a_rdata,     0);
      chk("rst_a_err",    bus.a_err,       0);
      chk("rst_b_err",    bus.b_err,       0);
      chk("rst_rd_en",    bus.mem_rd_en,   0);
      chk("rst_wr_en",    bus.mem_wr_en,   0);
      chk("rst_rd_addr",  bus.mem_rd_addr, 0);
      chk("rst_wr_addr",  bus.mem_wr_addr, 0);
      chk("rst_wr_data",  bus.mem_wr_data, 0);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      next_cycle();
      rst_n = 1'b1;

      // ---------------- 1: A write addr2=0x01, then A read addr2 ------------
      next_cycle();
      set_a(1'b1, 1'b1, 7'd2, 8'h01);
      #1;
      chk("t1_wr_a_gnt",   bus.a_gnt,       1);
      chk("t1_wr_b_gnt",   bus.b_gnt,       0);
      chk("t1_wr_en",      bus.mem_wr_en,   1);
      chk("t1_wr_addr",    bus.mem_wr_addr, 2);
      chk("t1_wr_data",    bus.mem_wr_data, 8'h01);
      chk("t1_wr_rd_en",   bus.mem_rd_en,   0);
      next_cycle();
      set_a(1'b1, 1'b0, 7'd2, 8'h00);
      #1;
      chk("t1_rd_a_gnt",   bus.a_gnt,       1);
      chk("t1_rd_en",      bus.mem_rd_en,   1);
      chk("t1_rd_addr",    bus.mem_rd_addr, 2);
      chk("t1_rd_wr_en",   bus.mem_wr_en,   0);
      chk("t1_rd_rvalid0", bus.a_rvalid,    0);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t1_idle_gnt",   bus.a_gnt,       0);
      chk("t1_idle_rd_en", bus.mem_rd_en,   0);
      chk("t1_rvalid",     bus.a_rvalid,    1);
      chk("t1_rdata",      bus.a_rdata,     8'h01);
      chk("t1_err",        bus.a_err,       0);
      next_cycle();
      #1;
      chk("t1_rvalid_one", bus.a_rvalid,    0);

      // ---------------- 2: A read addr5 + B write addr7=0x3C --------------
      next_cycle();
      set_a(1'b1, 1'b0, 7'd5, 8'h00);
      set_b(1'b1, 1'b1, 7'd7, 8'h3C);
      #1;
      chk("t2_a_gnt",      bus.a_gnt,       1);
      chk("t2_b_gnt",      bus.b_gnt,       1);
      chk("t2_rd_en",      bus.mem_rd_en,   1);
      chk("t2_wr_en",      bus.mem_wr_en,   1);
      chk("t2_rd_addr",    bus.mem_rd_addr, 5);
      chk("t2_wr_addr",    bus.mem_wr_addr, 7);
      chk("t2_wr_data",    bus.mem_wr_data, 8'h3C);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t2_a_rvalid",   bus.a_rvalid,    1);
      chk("t2_a_rdata",    bus.a_rdata,     8'h00);
      chk("t2_b_rvalid",   bus.b_rvalid,    0);

      // ---------------- 3: both read continuously, grants alternate -------
      next_cycle();
      set_a(1'b1, 1'b0, 7'd1, 8'h00);
      set_b(1'b1, 1'b0, 7'd2, 8'h00);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) next_cycle();
         #1;
         chk($sformatf("t3_a_gnt_%0d", k),    bus.a_gnt,       (k % 2 == 0) ? 1 : 0);
         chk($sformatf("t3_b_gnt_%0d", k),    bus.b_gnt,       (k % 2 == 1) ? 1 : 0);
         chk($sformatf("t3_rd_addr_%0d", k),  bus.mem_rd_addr, (k % 2 == 0) ? 1 : 2);
         chk($sformatf("t3_a_rvalid_%0d", k), bus.a_rvalid,    (k % 2 == 1) ? 1 : 0);
         chk($sformatf("t3_b_rvalid_%0d", k), bus.b_rvalid,    (k > 0 && k % 2 == 0) ? 1 : 0);
         if (k % 2 == 0 && k > 0) chk($sformatf("t3_b_rdata_%0d", k), bus.b_rdata, 8'h01);
      end
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t3_last_b_rvalid", bus.b_rvalid, 1);
      chk("t3_last_b_rdata",  bus.b_rdata,  8'h01);
      chk("t3_last_a_rvalid", bus.a_rvalid, 0);

      // ---------------- 4: A write addr9=0xAA vs B read addr9 -------------
      next_cycle();
      set_a(1'b1, 1'b1, 7'd9, 8'hAA);
      set_b(1'b1, 1'b0, 7'd9, 8'h00);
      #1;
      chk("t4_a_gnt",      bus.a_gnt,       1);
      chk("t4_b_gnt",      bus.b_gnt,       0);
      chk("t4_wr_en",      bus.mem_wr_en,   1);
      chk("t4_wr_addr",    bus.mem_wr_addr, 9);
      chk("t4_rd_en",      bus.mem_rd_en,   0);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t4_b_gnt2",     bus.b_gnt,       1);
      chk("t4_a_gnt2",     bus.a_gnt,       0);
      chk("t4_rd_en2",     bus.mem_rd_en,   1);
      chk("t4_rd_addr2",   bus.mem_rd_addr, 9);
      next_cycle();
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t4_b_rvalid",   bus.b_rvalid,    1);
      chk("t4_b_rdata",    bus.b_rdata,     8'hAA);

      // ---------------- 5: out-of-range accesses --------------------------
      next_cycle();
      set_b(1'b1, 1'b0, 7'd100, 8'h00);
      #1;
      chk("t5_b_gnt",      bus.b_gnt,       1);
      chk("t5_rd_en",      bus.mem_rd_en,   0);
      chk("t5_wr_en",      bus.mem_wr_en,   0);
      next_cycle();
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t5_b_err",      bus.b_err,       1);
      chk("t5_b_rvalid",   bus.b_rvalid,    1);
      chk("t5_b_rdata",    bus.b_rdata,     8'h00);
      chk("t5_a_err",      bus.a_err,       0);
      next_cycle();
      #1;
      chk("t5_b_err_one",  bus.b_err,       0);
      set_a(1'b1, 1'b1, 7'd127, 8'h55);
      #1;
      chk("t5_a_wr_gnt",   bus.a_gnt,       1);
      chk("t5_a_wr_en",    bus.mem_wr_en,   0);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t5_a_err",      bus.a_err,       1);
      chk("t5_a_rvalid",   bus.a_rvalid,    0);
      // Last legal address: B writes 99, then A reads it back.
      next_cycle();
      set_b(1'b1, 1'b1, 7'd99, 8'h5A);
      #1;
      chk("t5_wr99_en",    bus.mem_wr_en,   1);
      next_cycle();
      set_b(1'b0, 1'b0, 7'd0, 8'h00);
      set_a(1'b1, 1'b0, 7'd99, 8'h00);
      #1;
      chk("t5_rd99_en",    bus.mem_rd_en,   1);
      chk("t5_wr99_err",   bus.b_err,       0);
      next_cycle();
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      #1;
      chk("t5_rd99_data",  bus.a_rdata,     8'h5A);
      chk("t5_rd99_err",   bus.a_err,       0);

      // ---------------- 6: reset while a read is granted ------------------
      next_cycle();
      set_a(1'b1, 1'b0, 7'd2, 8'h00);
      #1;
      chk("t6_a_gnt",      bus.a_gnt,       1);
      chk("t6_rd_en",      bus.mem_rd_en,   1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_a_gnt",  bus.a_gnt,       0);
      chk("t6_rst_rd_en",  bus.mem_rd_en,   0);
      chk("t6_rst_rdaddr", bus.mem_rd_addr, 0);
      next_cycle();
      #1;
      chk("t6_rst_rvalid", bus.a_rvalid,    0);
      chk("t6_rst_rdata",  bus.a_rdata,     0);
      set_a(1'b0, 1'b0, 7'd0, 8'h00);
      rst_n = 1'b1;
      next_cycle();
      #1;
      chk("t6_rel_rvalid", bus.a_rvalid,    0);
      chk("t6_rel_err",    bus.a_err,       0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
